usb_rx_packet_fifo: RTL and testbench

USB_RX_PACKET_FIFO -- requirements
Module: usb_rx_packet_fifo

---
 rtl/usb_rx_packet_fifo.sv | 277 +++++++++++++++++++++++++++
 tb/tb_usb_rx_packet_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_fifo.sv
// USB Rx packet buffer: CRC strip, commit/rollback payload RAM, descriptor FIFO, stream out.
// Define USB_RX_FIFO_STATS_EN to build the saturating ok/crc/overflow packet counters.
module usb_rx_packet_fifo #(
  parameter int ADDR_WIDTH = 11,
  parameter int DESC_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_tvalid,
  input  logic                  s_tkeep,
  input  logic                  s_tlast,
  input  logic [3:0]            s_tuser,
  input  logic [7:0]            s_tdata,
  input  logic                  crc_valid_i,
  input  logic                  crc_error_i,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tkeep,
  output logic                  m_tlast,
  output logic [3:0]            m_tuser,
  output logic [7:0]            m_tdata,
  output logic                  drop_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic [15:0]           stat_ok_o,
  output logic [15:0]           stat_crc_o,
  output logic [15:0]           stat_ovf_o
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int DDEPTH = 1 << DESC_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [DESC_WIDTH:0] dptr_t;
  typedef struct packed {
    logic [3:0] pid;
    ptr_t       len;
  } desc_t;
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_DATA} tx_state_t;

  logic [7:0] mem [DEPTH];
  desc_t      dfifo [DDEPTH];

  rx_state_t rx_q, rx_d;
  tx_state_t tx_q, tx_d;

  ptr_t  wptr_q, cptr_q, rptr_q, rptr_d;
  ptr_t  wptr_inc, len, remain_q;
  dptr_t dwp_q, dwp_tx_q, drp_q, dcnt_q;

  logic [3:0] pid_q;
  logic [1:0] hcnt_q, hcnt_d;
  logic [7:0] h0_q, h1_q, h0_d, h1_d;
  logic [7:0] ram_q;

  logic  start, is_data, beat, last;
  logic  ram_full, desc_full, desc_avail;
  logic  ovf, wr_en, commit, rollback, ovf_drop;
  logic  xfer, pop, load, consume;
  desc_t head, new_desc;

  assign start    = s_tvalid && !s_tkeep && !s_tlast;
  assign is_data  = s_tuser[1:0] == 2'b11;
  assign beat     = s_tvalid && s_tkeep;
  assign last     = s_tvalid && s_tlast;

  assign ram_full = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0])
                 && (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
  assign desc_full  = dcnt_q == dptr_t'(DDEPTH);
  // Tx sees pushes one cycle late so the last committed byte has settled in ram_q
  assign desc_avail = dwp_tx_q != drp_q;

  assign ovf = (rx_q == RX_RECV) && beat && (hcnt_q == 2'd2) && ram_full;

  assign wptr_inc = wptr_q + ptr_t'(wr_en);
  assign len      = wptr_inc - cptr_q;
  assign level_o  = cptr_q - rptr_q;

  always_comb begin
    new_desc     = '0;
    new_desc.pid = pid_q;
    new_desc.len = len;
  end

  // Rx state register
  always_ff @(posedge clock) begin
    if (reset) rx_q <= RX_IDLE;
    else       rx_q <= rx_d;
  end

  // Rx next state
  always_comb begin
    rx_d = rx_q;
    unique case (rx_q)
      RX_IDLE: begin
        if (start && is_data)
          rx_d = desc_full ? RX_DROP : RX_RECV;
      end
      RX_RECV, RX_DROP: begin
        if (start)
          rx_d = !is_data ? RX_IDLE
               : desc_full ? RX_DROP : RX_RECV;
        else if (last)
          rx_d = RX_IDLE;
        else if (ovf)
          rx_d = RX_DROP;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Rx outputs: holding pipeline, RAM write, commit/rollback
  always_comb begin
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    ovf_drop = 1'b0;
    hcnt_d   = hcnt_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    if (start) begin
      hcnt_d   = '0;
      rollback = rx_q != RX_IDLE;
    end else if (rx_q == RX_RECV) begin
      if (beat && !ovf) begin
        unique case (hcnt_q)
          2'd0: begin
            h0_d   = s_tdata;
            hcnt_d = 2'd1;
          end
          2'd1: begin
            h1_d   = s_tdata;
            hcnt_d = 2'd2;
          end
          default: begin
            wr_en = 1'b1;
            h0_d  = h1_q;
            h1_d  = s_tdata;
          end
        endcase
      end
      if (last) begin
        commit   = crc_valid_i && !crc_error_i && !ovf;
        rollback = !commit;
        ovf_drop = ovf;
      end
    end else if (rx_q == RX_DROP && last) begin
      rollback = 1'b1;
      ovf_drop = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q   <= '0;
      cptr_q   <= '0;
      hcnt_q   <= '0;
      dwp_q    <= '0;
      dwp_tx_q <= '0;
      dcnt_q   <= '0;
      drop_o   <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      drop_o   <= ovf_drop;
      dwp_tx_q <= dwp_q;
      wptr_q   <= rollback ? cptr_q : wptr_inc;
      if (commit) begin
        cptr_q <= wptr_inc;
        dwp_q  <= dwp_q + dptr_t'(1);
      end
      // a descriptor slot stays occupied until its final beat leaves
      dcnt_q <= dcnt_q + dptr_t'(commit)
              - dptr_t'(xfer && m_tlast);
    end
  end

  always_ff @(posedge clock) begin
    h0_q <= h0_d;
    h1_q <= h1_d;
    if (start) pid_q <= s_tuser;
    if (wr_en) mem[wptr_q[ADDR_WIDTH-1:0]] <= h0_q;
    if (commit) dfifo[dwp_q[DESC_WIDTH-1:0]] <= new_desc;
    ram_q <= mem[rptr_d[ADDR_WIDTH-1:0]];
  end

  assign head = dfifo[drp_q[DESC_WIDTH-1:0]];
  assign xfer = m_tvalid && m_tready;

  // Tx state register
  always_ff @(posedge clock) begin
    if (reset) tx_q <= TX_IDLE;
    else       tx_q <= tx_d;
  end

  // Tx next state
  always_comb begin
    tx_d = tx_q;
    unique case (tx_q)
      TX_IDLE: if (desc_avail) tx_d = TX_DATA;
      TX_DATA: if (xfer && m_tlast && !desc_avail) tx_d = TX_IDLE;
      default: tx_d = TX_IDLE;
    endcase
  end

  // Tx outputs: descriptor pop and next-byte load
  always_comb begin
    pop  = 1'b0;
    load = 1'b0;
    unique case (1'b1)
      tx_q == TX_IDLE:                      pop  = desc_avail;
      tx_q == TX_DATA && xfer && m_tlast:   pop  = desc_avail;
      tx_q == TX_DATA && xfer && !m_tlast:  load = 1'b1;
      default: ;
    endcase
    consume = load || (pop && head.len != '0);
    rptr_d  = rptr_q + ptr_t'(consume);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rptr_q   <= '0;
      drp_q    <= '0;
      m_tvalid <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      if (pop) begin
        drp_q    <= drp_q + dptr_t'(1);
        m_tvalid <= 1'b1;
      end else if (xfer && !load) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (pop) begin
      m_tuser  <= head.pid;
      m_tdata  <= ram_q;
      m_tkeep  <= head.len != '0;
      m_tlast  <= head.len <= ptr_t'(1);
      remain_q <= (head.len == '0) ? '0 : head.len - ptr_t'(1);
    end else if (load) begin
      m_tdata  <= ram_q;
      m_tkeep  <= 1'b1;
      m_tlast  <= remain_q == ptr_t'(1);
      remain_q <= remain_q - ptr_t'(1);
    end
  end

`ifdef USB_RX_FIFO_STATS_EN
  logic        crc_drop;
  logic [15:0] ok_q, crc_q, ovf_q;

  assign crc_drop = (rx_q == RX_RECV) && !start && last
                 && crc_error_i && !ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      ok_q  <= '0;
      crc_q <= '0;
      ovf_q <= '0;
    end else begin
      if (commit && ok_q != 16'hFFFF)    ok_q  <= ok_q + 16'd1;
      if (crc_drop && crc_q != 16'hFFFF) crc_q <= crc_q + 16'd1;
      if (ovf_drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  assign stat_ok_o  = ok_q;
  assign stat_crc_o = crc_q;
  assign stat_ovf_o = ovf_q;
`else
  assign stat_ok_o  = '0;
  assign stat_crc_o = '0;
  assign stat_ovf_o = '0;
`endif

endmodule

// File: tb/tb_usb_rx_packet_fifo.sv
// Scoreboard bench for usb_rx_packet_fifo with a 16-byte payload RAM.
// Stats expectations follow USB_RX_FIFO_STATS_EN.
module tb_usb_rx_packet_fifo;
  localparam int AW = 4;
  localparam int DW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          s_tvalid, s_tkeep, s_tlast;
  logic [3:0]    s_tuser;
  logic [7:0]    s_tdata;
  logic          crc_valid_i, crc_error_i;
  logic          m_tvalid, m_tready, m_tkeep, m_tlast;
  logic [3:0]    m_tuser;
  logic [7:0]    m_tdata;
  logic          drop_o;
  logic [AW:0]   level_o;
  logic [15:0]   stat_ok_o, stat_crc_o, stat_ovf_o;

  usb_rx_packet_fifo #(.ADDR_WIDTH(AW), .DESC_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tdata(s_tdata),
    .crc_valid_i(crc_valid_i), .crc_error_i(crc_error_i),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdata(m_tdata),
    .drop_o(drop_o), .level_o(level_o),
    .stat_ok_o(stat_ok_o), .stat_crc_o(stat_crc_o), .stat_ovf_o(stat_ovf_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic [3:0] u;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;

  // monitor: every accepted output beat is compared with the queue head
  always @(negedge clock) begin
    if (!reset && m_tvalid && m_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got d=%h k=%b l=%b u=%h, required no beat",
                 m_tdata, m_tkeep, m_tlast, m_tuser);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_tkeep !== mon_e.k || m_tlast !== mon_e.l || m_tuser !== mon_e.u
            || (mon_e.k && m_tdata !== mon_e.d)) begin
          errors++;
          $display("FAIL out_beat: got d=%h k=%b l=%b u=%h, required d=%h k=%b l=%b u=%h",
                   m_tdata, m_tkeep, m_tlast, m_tuser,
                   mon_e.d, mon_e.k, mon_e.l, mon_e.u);
        end
      end
    end
    if (!reset && drop_o) drop_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic k, input logic l,
                             input logic [3:0] u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    exp_q.push_back(b);
  endtask

  task automatic drive(input logic v, input logic k, input logic l,
                       input logic [3:0] u, input logic [7:0] d,
                       input logic cv, input logic ce);
    @(posedge clock); #1;
    s_tvalid = v; s_tkeep = k; s_tlast = l;
    s_tuser = u; s_tdata = d;
    crc_valid_i = cv; crc_error_i = ce;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  // PID beat, n payload bytes base+i, then two CRC bytes (flags on the last)
  task automatic send_pkt(input logic [3:0] pid, input int n, input logic [7:0] base,
                          input logic cv, input logic ce);
    drive(1'b1, 1'b0, 1'b0, pid, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, 1'b0, pid, base + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, pid, 8'hC1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, pid, 8'hC2, cv, ce);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    s_tvalid = 0; s_tkeep = 0; s_tlast = 0; s_tuser = 0; s_tdata = 0;
    crc_valid_i = 0; crc_error_i = 0; m_tready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_level", level_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_stat_ok", stat_ok_o, 0);
    chk("rst_stat_ovf", stat_ovf_o, 0);

    // DATA0 01 02 03, good CRC
    expect_beat(8'h01, 1, 0, 4'h3);
    expect_beat(8'h02, 1, 0, 4'h3);
    expect_beat(8'h03, 1, 1, 4'h3);
    send_pkt(4'h3, 3, 8'h01, 1'b1, 1'b0);
    idle();
    @(negedge clock);
    chk("t1_level_after_commit", level_o, 3);
    chk("t1_valid_cycle0", m_tvalid, 0);
    @(negedge clock);
    chk("t1_valid_cycle1", m_tvalid, 0);
    @(negedge clock);
    chk("t1_valid_cycle2", m_tvalid, 1);
    wait_drain("t1");
    chk("t1_level_end", level_o, 0);

    // same packet, CRC error
    send_pkt(4'h3, 3, 8'h01, 1'b0, 1'b1);
    idle();
    repeat (6) @(negedge clock);
    chk("t2_level", level_o, 0);
    chk("t2_m_tvalid", m_tvalid, 0);
`ifdef USB_RX_FIFO_STATS_EN
    chk("t2_stat_crc", stat_crc_o, 1);
`else
    chk("t2_stat_crc", stat_crc_o, 0);
`endif

    // DATA1 zero-length
    expect_beat(8'h00, 0, 1, 4'hB);
    send_pkt(4'hB, 0, 8'h00, 1'b1, 1'b0);
    idle();
    wait_drain("t3");

    // 20-byte packet overflows the 16-byte RAM, then a 4-byte packet
    send_pkt(4'h3, 20, 8'h40, 1'b1, 1'b0);
    idle();
    repeat (3) @(negedge clock);
    chk("t4_drop_cnt", drop_cnt, 1);
    chk("t4_level", level_o, 0);
    expect_beat(8'hA0, 1, 0, 4'hB);
    expect_beat(8'hA1, 1, 0, 4'hB);
    expect_beat(8'hA2, 1, 0, 4'hB);
    expect_beat(8'hA3, 1, 1, 4'hB);
    send_pkt(4'hB, 4, 8'hA0, 1'b1, 1'b0);
    idle();
    wait_drain("t4");

    // nine 1-byte packets against a stalled sink
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++)
      expect_beat(8'h10 + 8'(i), 1, 1, 4'h3);
    for (int i = 0; i < 9; i++)
      send_pkt(4'h3, 1, 8'h10 + 8'(i), 1'b1, 1'b0);
    idle();
    repeat (3) @(negedge clock);
    chk("t5_drop_cnt", drop_cnt, 2);
    chk("t5_stall_valid", m_tvalid, 1);
    chk("t5_stall_data", m_tdata, 8'h10);
    repeat (3) @(negedge clock);
    chk("t5_hold_data", m_tdata, 8'h10);
    chk("t5_hold_last", m_tlast, 1);
    chk("t5_hold_user", m_tuser, 4'h3);
    @(posedge clock); #1 m_tready = 1'b1;
    wait_drain("t5");
    chk("t5_level_end", level_o, 0);
`ifdef USB_RX_FIFO_STATS_EN
    chk("stat_ok", stat_ok_o, 11);
    chk("stat_ovf", stat_ovf_o, 2);
    chk("stat_crc", stat_crc_o, 1);
`else
    chk("stat_ok", stat_ok_o, 0);
    chk("stat_ovf", stat_ovf_o, 0);
`endif

    // reset at the 2nd payload byte, then a good 2-byte packet
    drive(1'b1, 1'b0, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'h3, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'h3, 8'h66, 1'b0, 1'b0);
    reset = 1'b1;
    idle();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t6_rst_valid", m_tvalid, 0);
    chk("t6_rst_level", level_o, 0);
    chk("t6_rst_stat_ok", stat_ok_o, 0);
    expect_beat(8'hD0, 1, 0, 4'h3);
    expect_beat(8'hD1, 1, 1, 4'h3);
    send_pkt(4'h3, 2, 8'hD0, 1'b1, 1'b0);
    idle();
    wait_drain("t6");

    // reset while a beat waits at a stalled sink
    m_tready = 1'b0;
    send_pkt(4'h3, 2, 8'hE0, 1'b1, 1'b0);
    idle();
    begin
      int n;
      n = 0;
      while (!m_tvalid && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    chk("t7_valid_before_reset", m_tvalid, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t7_valid_after_reset", m_tvalid, 0);
    m_tready = 1'b1;
    repeat (6) @(negedge clock);
    chk("t7_level", level_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
